tff_mod_counter: RTL and testbench

- Parametrised synchronous counter; next generation of the toggle-flip-flop counter family in the four-bit counter design.
- Replaces the fixed four-bit ripple chain with a single-clock WIDTH-bit counter.
- Adds programmable modulus, up/down direction, parallel load, synchronous clear, saturate-or-wrap mode, and wrap/error status.
- Used as the general count source for dividers, display sequencing and event counting.

---
 rtl/tff_mod_counter.sv | 101 ++++++++++
 tb/tb_tff_mod_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tff_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tff_mod_counter
//  Description : Parametrised modulo-MODULUS up/down counter.
//                It has parallel load, synchronous clear, and a wrap or
//                saturate mode. It reports a terminal count, a one-cycle
//                wrap pulse and a sticky illegal-load error.
//                State updates on the falling edge of clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tff_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    // MODULUS may equal 2^WIDTH, so the range check needs one extra bit.
    localparam logic [WIDTH:0]   c_mod  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam bit               c_sat  = (SATURATE != 0);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_err_nxt;
    logic             w_load_ok;

    assign w_load_ok = ({1'b0, load_val} < c_mod);

    // Next-state selection; the priority is clear, then load, then count enable.
    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        w_err_nxt  = r_err;
        if (clear) begin
            w_q_nxt   = c_zero;
            w_err_nxt = 1'b0;
        end else if (load) begin
            if (w_load_ok) begin
                w_q_nxt = load_val;
            end else begin
                w_q_nxt   = c_max;
                w_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (r_q == c_max) begin
                    w_wrap_nxt = 1'b1;
                    w_q_nxt    = c_sat ? r_q : c_zero;
                end else begin
                    w_q_nxt = r_q + c_one;
                end
            end else begin
                if (r_q == c_zero) begin
                    w_wrap_nxt = 1'b1;
                    w_q_nxt    = c_sat ? r_q : c_max;
                end else begin
                    w_q_nxt = r_q - c_one;
                end
            end
        end
    end

    // Count and status registers, falling-edge clocked, asynchronous active-low reset.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
            r_err  <= w_err_nxt;
        end
    end

    // The terminal count follows the current direction with no register stage.
    assign tc   = up_dn ? (r_q == c_max) : (r_q == c_zero);
    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tff_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tff_mod_counter
//  Description : Directed self-checking bench for tff_mod_counter.
//                It drives a wrap instance and a saturate instance
//                (WIDTH=4, MODULUS=10) in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clear;

    logic [WIDTH-1:0] q_w, q_s;
    logic             tc_w, tc_s, wrap_w, wrap_s, err_w, err_s;

    int n_tests = 0;
    int n_fail  = 0;

    tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear),
        .q(q_w), .tc(tc_w), .wrap(wrap_w), .err(err_w)
    );

    tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear),
        .q(q_s), .tc(tc_s), .wrap(wrap_s), .err(err_s)
    );

    // Free-running clock, 10 time-unit period; the DUT acts on the falling edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one active (falling) edge, then settle before sampling.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = '0; clear = 1'b0;
        #12;

        // Reset state and combinational tc
        chk("rst_q",    q_w, 0);
        chk("rst_wrap", wrap_w, 0);
        chk("rst_err",  err_w, 0);
        chk("rst_tc_up", tc_w, 0);
        up_dn = 1'b0; #1;
        chk("rst_tc_dn", tc_w, 1);
        up_dn = 1'b1; #1;
        chk("rst_tc_up2", tc_w, 0);
        reset = 1'b1;

        // Count up 12 edges
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int ew, es;
            step();
            ew = (i + 1) % 10;
            es = (i + 1 > 9) ? 9 : i + 1;
            chk($sformatf("up_q[%0d]", i),    q_w, ew);
            chk($sformatf("up_wrap[%0d]", i), wrap_w, (i == 9) ? 1 : 0);
            chk($sformatf("up_tc[%0d]", i),   tc_w, (ew == 9) ? 1 : 0);
            chk($sformatf("sat_up_q[%0d]", i),    q_s, es);
            chk($sformatf("sat_up_wrap[%0d]", i), wrap_s, (i >= 9) ? 1 : 0);
        end

        // Clear wins over en
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_q", q_w, 0);
        chk("clr_wrap_sat", wrap_s, 0);
        up_dn = 1'b0; #1;
        chk("dn_tc_at0", tc_w, 1);

        // Count down from 0
        begin
            int exp_q [3] = '{9, 8, 7};
            int exp_wr[3] = '{1, 0, 0};
            for (int i = 0; i < 3; i++) begin
                step();
                chk($sformatf("dn_q[%0d]", i),    q_w, exp_q[i]);
                chk($sformatf("dn_wrap[%0d]", i), wrap_w, exp_wr[i]);
                chk($sformatf("sat_dn_q[%0d]", i),    q_s, 0);
                chk($sformatf("sat_dn_wrap[%0d]", i), wrap_s, 1);
            end
        end

        // Load 7 with en high: load has priority, so no increment
        up_dn = 1'b1; load = 1'b1; load_val = 4'd7; step(); load = 1'b0;
        chk("ld7_q",     q_w, 7);
        chk("ld7_q_sat", q_s, 7);
        chk("ld7_wrap",  wrap_s, 0);
        begin
            int es [5] = '{8, 9, 9, 9, 9};
            int esw[5] = '{0, 0, 1, 1, 1};
            int ew [5] = '{8, 9, 0, 1, 2};
            int eww[5] = '{0, 0, 1, 0, 0};
            for (int i = 0; i < 5; i++) begin
                step();
                chk($sformatf("sat7_q[%0d]", i),    q_s, es[i]);
                chk($sformatf("sat7_wrap[%0d]", i), wrap_s, esw[i]);
                chk($sformatf("wrp7_q[%0d]", i),    q_w, ew[i]);
                chk($sformatf("wrp7_wrap[%0d]", i), wrap_w, eww[i]);
            end
        end

        // Hold with en low
        en = 1'b0; step();
        chk("hold_q",    q_w, 2);
        chk("hold_wrap", wrap_s, 0);

        // Illegal load 12 -> MODULUS-1, sticky err
        load = 1'b1; load_val = 4'd12; step(); load = 1'b0;
        chk("ld12_q",   q_w, 9);
        chk("ld12_err", err_w, 1);
        en = 1'b1; step();
        chk("ld12_cnt_q",    q_w, 0);
        chk("ld12_cnt_wrap", wrap_w, 1);
        chk("ld12_cnt_err",  err_w, 1);
        chk("ld12_sat_q",    q_s, 9);
        chk("ld12_sat_err",  err_s, 1);
        en = 1'b0; clear = 1'b1; step(); clear = 1'b0;
        chk("clr_err_q",   q_w, 0);
        chk("clr_err_err", err_w, 0);

        // Boundary loads: 10 is illegal, 9 is legal
        load = 1'b1; load_val = 4'd9; step();
        chk("ld9_q",   q_w, 9);
        chk("ld9_err", err_w, 0);
        load_val = 4'd10; step(); load = 1'b0;
        chk("ld10_q",   q_w, 9);
        chk("ld10_err", err_w, 1);
        clear = 1'b1; step(); clear = 1'b0;

        // Clear + load + en together -> 0; then load + en -> 5
        clear = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; step();
        chk("cle_q", q_w, 0);
        clear = 1'b0; step(); load = 1'b0;
        chk("le_q", q_w, 5);

        // Mid-cycle asynchronous reset at q=6 with err set
        en = 1'b0; load = 1'b1; load_val = 4'd12; step();
        load_val = 4'd6; step(); load = 1'b0;
        chk("pre_rst_q",   q_w, 6);
        chk("pre_rst_err", err_w, 1);
        #2; reset = 1'b0; #1;
        chk("arst_q",    q_w, 0);
        chk("arst_wrap", wrap_s, 0);
        chk("arst_err",  err_w, 0);
        chk("arst_q_sat", q_s, 0);
        #2; reset = 1'b1; en = 1'b1; up_dn = 1'b1;
        step();
        chk("post_rst_q",     q_w, 1);
        chk("post_rst_q_sat", q_s, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
